gpr_bus_sequencer: RTL and testbench
====================================

// Module: gpr_bus_sequencer
// PURPOSE
//  Sequences the bank of general purpose registers and their three 8-bit buses (Main, LHS, RHS).
//  Takes one register-transfer op per handshake and drives the per-register controls:
//  load (active rising) and the active-low assert lines a_main_n, a_lhs_n and a_rhs_n.
//  It also drives the external Main-bus source and sink strobes.
//  Guarantees at most one driver per bus, with an idle turnaround cycle between ops.
// PARAMETERS
//  NUM_REGS   4   number of GPRs controlled (A,B,C,D); legal range 1..4
//  IDX_W      2   width of register index fields
// PORTS
//  clk           in   1         system clock; all state updates on rising edge
//  rst_n         in   1         reset, asynchronous assert, active-low
//  op_valid      in   1         op request
//  op_ready      out  1         sequencer can accept op (high only in IDLE)
//  op_code       in   2         0 LOAD_EXT, 1 MOV, 2 ALU_READ, 3 STORE_EXT
//  dst_idx       in   IDX_W     destination register (LOAD_EXT, MOV)
//  src_idx       in   IDX_W     source register (MOV, STORE_EXT) / LHS source (ALU_READ)
//  rhs_idx       in   IDX_W     RHS source (ALU_READ)
//  load          out  NUM_REGS  per-GPR load, rising edge captures MainBus
//  a_main_n      out  NUM_REGS  per-GPR Main-bus assert, active-low
//  a_lhs_n       out  NUM_REGS  per-GPR LHS-bus assert, active-low
//  a_rhs_n       out  NUM_REGS  per-GPR RHS-bus assert, active-low
//  ext_drive_n   out  1         external source drives MainBus, active-low
//  ext_capture   out  1         external sink captures MainBus (pulse)
//  alu_capture   out  1         ALU samples LHS/RHS (pulse)
//  done          out  1         one-cycle pulse, op retired
//  err           out  1         one-cycle pulse with done, index >= NUM_REGS
// BEHAVIOUR
//  - All outputs are registered. Reset values: load=0, a_*_n=all 1s, ext_drive_n=1,
//    ext_capture=0, alu_capture=0, done=0, err=0, op_ready=1, state=IDLE.
//  - FSM: IDLE -> SETUP -> STROBE -> RELEASE -> IDLE. An op is accepted on op_valid&op_ready in IDLE.
//    Operands are latched at accept. Fixed 4-cycle period per op: no back-to-back ops.
//    The IDLE cycle is the bus turnaround.
//  - SETUP: assert bus drivers only.
//    LOAD_EXT: ext_drive_n=0. MOV: a_main_n[src]=0. STORE_EXT: a_main_n[src]=0.
//    ALU_READ: a_lhs_n[src]=0 and a_rhs_n[rhs]=0.
//  - STROBE: drivers held. Exactly one capture strobe is asserted:
//    load[dst]=1 (LOAD_EXT, MOV), ext_capture=1 (STORE_EXT), alu_capture=1 (ALU_READ).
//  - RELEASE: strobe deasserted, drivers still held (hold time after the edge), done=1.
//    Next edge: drivers off, op_ready=1.
//  - MOV with src==dst: no bus activity, no load. FSM still walks all states, done pulses in RELEASE.
//  - ALU_READ with src==rhs is legal: one register asserts both LHS and RHS.
//  - Any used index >= NUM_REGS: no drivers or strobes for the whole op, done=1 and err=1 in RELEASE.
//  - op_valid while busy is ignored; the requester holds op_valid until accepted.
//    Operand changes while busy have no effect.
//  - Invariants, at every cycle:
//    count(~a_main_n) + ~ext_drive_n <= 1; count(~a_lhs_n) <= 1; count(~a_rhs_n) <= 1; popcount(load) <= 1.
//    load / capture strobes are only high when their bus driver was already asserted the previous cycle.
//  - rst_n low mid-op: all drivers and strobes drop immediately (async), op is abandoned, no done.
// STRUCTURE
//  - Shared include gpr_seq_defs.vh: op-code localparams (OP_LOAD_EXT..OP_STORE_EXT),
//    state encodings (ST_IDLE..ST_RELEASE).
//  - Sub-module gpr_onehot_decode (IDX_W in, NUM_REGS out, en, valid flag for range check).
//    Instantiated for dst, src and rhs. Active-low outputs are formed by inversion in the parent.
// TESTING
//  - Reset then idle: op_ready=1, a_main_n=a_lhs_n=a_rhs_n=4'hF, load=0, ext_drive_n=1, 5 cycles stable.
//  - LOAD_EXT dst=2, TB drives MainBus=8'hAA on ext_drive_n:
//    ext_drive_n low cycles 1-3, load=4'b0100 in cycle 2 only, done cycle 3; GPR C reads 8'hAA on LHS.
//  - MOV src=2 dst=0: a_main_n=4'b1011 cycles 1-3, load=4'b0001 cycle 2; GPR A then holds 8'hAA.
//  - ALU_READ src=0 rhs=2: a_lhs_n=4'b1110, a_rhs_n=4'b1011 cycles 1-3, alu_capture cycle 2;
//    LHS=RHS=8'hAA. Also src==rhs=1 gives a_lhs_n=a_rhs_n=4'b1101.
//  - Back-to-back op_valid held high for 3 ops: accepts exactly every 4 cycles, no driver overlap.
//    MOV src=dst=3 produces done with all-1s/zeros outputs.
//  - NUM_REGS=3 with dst=3: err=done=1 in RELEASE, no strobes.
//    Assert rst_n=0 during STROBE of a MOV: all outputs at reset values within the same cycle, no done.

Source files
------------

// File: rtl/gpr_bus_sequencer_pkg.sv
// Shared op-code and state encodings for the GPR bus sequencer.
// Also holds helpers that say which register indices an op reads or writes.
package gpr_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_EXT  = 2'd0,
    OP_MOV       = 2'd1,
    OP_ALU_READ  = 2'd2,
    OP_STORE_EXT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  function automatic logic op_uses_dst(input op_e op);
    return (op == OP_LOAD_EXT) || (op == OP_MOV);
  endfunction

  function automatic logic op_uses_src(input op_e op);
    return op != OP_LOAD_EXT;
  endfunction

  function automatic logic op_uses_rhs(input op_e op);
    return op == OP_ALU_READ;
  endfunction

endpackage

// File: rtl/gpr_bus_sequencer_onehot_decode.sv
// Register index to one-hot select, gated by en.
// valid reports whether the index names an existing register.
module gpr_bus_sequencer_onehot_decode #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot,
  output logic                valid
);

  assign valid = int'(idx) < NUM_REGS;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
    assign onehot[gi] = en && valid && (int'(idx) == gi);
  end

endmodule

// File: rtl/gpr_bus_sequencer.sv
// Four-phase register-transfer sequencer for the Main/LHS/RHS GPR buses.
// Every output is a register computed from the state being entered.
module gpr_bus_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_code,
  input  logic [IDX_W-1:0]    dst_idx,
  input  logic [IDX_W-1:0]    src_idx,
  input  logic [IDX_W-1:0]    rhs_idx,
  output logic [NUM_REGS-1:0] load,
  output logic [NUM_REGS-1:0] a_main_n,
  output logic [NUM_REGS-1:0] a_lhs_n,
  output logic [NUM_REGS-1:0] a_rhs_n,
  output logic                ext_drive_n,
  output logic                ext_capture,
  output logic                alu_capture,
  output logic                done,
  output logic                err
);

  import gpr_bus_sequencer_pkg::*;

  state_e              state_reg, state_next;
  op_e                 op_reg;
  logic [IDX_W-1:0]    dst_reg, src_reg, rhs_reg;

  logic                op_ready_reg, ext_drive_n_reg, ext_capture_reg, alu_capture_reg;
  logic                done_reg, err_reg;
  logic [NUM_REGS-1:0] load_reg, a_main_n_reg, a_lhs_n_reg, a_rhs_n_reg;

  logic                accept;
  op_e                 op_eff;
  logic [IDX_W-1:0]    dst_eff, src_eff, rhs_eff;
  logic                dst_ok, src_ok, rhs_ok, err_op, quiet;
  logic                drive_en, strobe_en;
  logic [NUM_REGS-1:0] dst_oh, src_oh, rhs_oh;

  // On the accept edge the operand registers are not yet loaded, so SETUP
  // outputs must be decoded straight from the request inputs.
  assign accept  = (state_reg == ST_IDLE) && op_valid;
  assign op_eff  = accept ? op_e'(op_code) : op_reg;
  assign dst_eff = accept ? dst_idx : dst_reg;
  assign src_eff = accept ? src_idx : src_reg;
  assign rhs_eff = accept ? rhs_idx : rhs_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (op_valid) state_next = ST_SETUP;
      ST_SETUP:   state_next = ST_STROBE;
      ST_STROBE:  state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign err_op    = (op_uses_dst(op_eff) && !dst_ok) ||
                     (op_uses_src(op_eff) && !src_ok) ||
                     (op_uses_rhs(op_eff) && !rhs_ok);
  // Bad indices and self-moves walk the FSM but never touch a bus.
  assign quiet     = err_op || ((op_eff == OP_MOV) && (src_eff == dst_eff));
  assign drive_en  = (state_next != ST_IDLE) && !quiet;
  assign strobe_en = (state_next == ST_STROBE) && !quiet;

  gpr_bus_sequencer_onehot_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dst_dec (
    .idx(dst_eff), .en(strobe_en && op_uses_dst(op_eff)), .onehot(dst_oh), .valid(dst_ok)
  );
  gpr_bus_sequencer_onehot_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_src_dec (
    .idx(src_eff), .en(drive_en && op_uses_src(op_eff)), .onehot(src_oh), .valid(src_ok)
  );
  gpr_bus_sequencer_onehot_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rhs_dec (
    .idx(rhs_eff), .en(drive_en && op_uses_rhs(op_eff)), .onehot(rhs_oh), .valid(rhs_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      op_reg          <= OP_LOAD_EXT;
      dst_reg         <= '0;
      src_reg         <= '0;
      rhs_reg         <= '0;
      op_ready_reg    <= 1'b1;
      load_reg        <= '0;
      a_main_n_reg    <= '1;
      a_lhs_n_reg     <= '1;
      a_rhs_n_reg     <= '1;
      ext_drive_n_reg <= 1'b1;
      ext_capture_reg <= 1'b0;
      alu_capture_reg <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg  <= op_e'(op_code);
        dst_reg <= dst_idx;
        src_reg <= src_idx;
        rhs_reg <= rhs_idx;
      end
      op_ready_reg    <= state_next == ST_IDLE;
      load_reg        <= dst_oh;
      a_main_n_reg    <= ~(src_oh & {NUM_REGS{(op_eff == OP_MOV) || (op_eff == OP_STORE_EXT)}});
      a_lhs_n_reg     <= ~(src_oh & {NUM_REGS{op_eff == OP_ALU_READ}});
      a_rhs_n_reg     <= ~rhs_oh;
      ext_drive_n_reg <= !(drive_en && (op_eff == OP_LOAD_EXT));
      ext_capture_reg <= strobe_en && (op_eff == OP_STORE_EXT);
      alu_capture_reg <= strobe_en && (op_eff == OP_ALU_READ);
      done_reg        <= state_next == ST_RELEASE;
      err_reg         <= (state_next == ST_RELEASE) && err_op;
    end
  end

  assign op_ready    = op_ready_reg;
  assign load        = load_reg;
  assign a_main_n    = a_main_n_reg;
  assign a_lhs_n     = a_lhs_n_reg;
  assign a_rhs_n     = a_rhs_n_reg;
  assign ext_drive_n = ext_drive_n_reg;
  assign ext_capture = ext_capture_reg;
  assign alu_capture = alu_capture_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_gpr_bus_sequencer.sv
// Bench for gpr_bus_sequencer: 4-register and 3-register instances share stimulus;
// a phase-counter model plus a small GPR data model check every cycle.
module tb_gpr_bus_sequencer;

  localparam logic [1:0] LD = 2'd0, MV = 2'd1, AL = 2'd2, ST = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       op_valid = 1'b0;
  logic [1:0] op_code = 2'd0, dst_idx = 2'd0, src_idx = 2'd0, rhs_idx = 2'd0;
  logic [7:0] ext_data = 8'h00;

  always #5 clk = ~clk;

  logic       op_ready4, extd4, extc4, aluc4, done4, err4;
  logic [3:0] load4, main4, lhs4, rhs4;
  logic       op_ready3, extd3, extc3, aluc3, done3, err3;
  logic [2:0] load3, main3, lhs3, rhs3;

  gpr_bus_sequencer #(.NUM_REGS(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready4), .op_code(op_code),
    .dst_idx(dst_idx), .src_idx(src_idx), .rhs_idx(rhs_idx), .load(load4), .a_main_n(main4),
    .a_lhs_n(lhs4), .a_rhs_n(rhs4), .ext_drive_n(extd4), .ext_capture(extc4),
    .alu_capture(aluc4), .done(done4), .err(err4)
  );

  gpr_bus_sequencer #(.NUM_REGS(3), .IDX_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready3), .op_code(op_code),
    .dst_idx(dst_idx), .src_idx(src_idx), .rhs_idx(rhs_idx), .load(load3), .a_main_n(main3),
    .a_lhs_n(lhs3), .a_rhs_n(rhs3), .ext_drive_n(extd3), .ext_capture(extc3),
    .alu_capture(aluc3), .done(done3), .err(err3)
  );

  typedef struct packed {
    logic [3:0] load, main_n, lhs_n, rhs_n;
    logic       ready, ext_drive_n, ext_cap, alu_cap, done, err;
  } outs_t;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: position of the current op inside its fixed four-cycle window.
  int         phase = 0;
  logic [1:0] m_op = 2'd0, m_dst = 2'd0, m_src = 2'd0, m_rhs = 2'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase = 0;
    else if (phase == 0) begin
      if (op_valid) begin
        m_op = op_code; m_dst = dst_idx; m_src = src_idx; m_rhs = rhs_idx;
        phase = 1;
      end
    end else phase = (phase + 1) % 4;
  end

  function automatic outs_t expect_outs(input int ph, input logic [1:0] op, input logic [1:0] d,
                                        input logic [1:0] s, input logic [1:0] r, input int nregs);
    outs_t e;
    bit    bad_idx, quiet;
    e = '{load: 4'h0, main_n: 4'hF, lhs_n: 4'hF, rhs_n: 4'hF, ready: 1'b0,
          ext_drive_n: 1'b1, ext_cap: 1'b0, alu_cap: 1'b0, done: 1'b0, err: 1'b0};
    e.ready = (ph == 0);
    bad_idx = ((op == LD || op == MV) && int'(d) >= nregs) ||
              (op != LD && int'(s) >= nregs) || (op == AL && int'(r) >= nregs);
    quiet = bad_idx || (op == MV && s == d);
    if (ph != 0 && !quiet) begin
      case (op)
        LD:      e.ext_drive_n = 1'b0;
        AL:      begin e.lhs_n[s] = 1'b0; e.rhs_n[r] = 1'b0; end
        default: e.main_n[s] = 1'b0;
      endcase
      if (ph == 2) begin
        case (op)
          ST:      e.ext_cap = 1'b1;
          AL:      e.alu_cap = 1'b1;
          default: e.load[d] = 1'b1;
        endcase
      end
    end
    if (ph == 3) begin e.done = 1'b1; e.err = bad_idx; end
    return e;
  endfunction

  // Per-cycle compare against the model, plus bus-exclusivity invariants.
  logic prev_mdrv = 1'b0, prev_ldrv = 1'b0, prev_rdrv = 1'b0;
  always @(negedge clk) begin
    outs_t a4, a3;
    logic  hold_ok;
    a4 = {load4, main4, lhs4, rhs4, op_ready4, extd4, extc4, aluc4, done4, err4};
    a3 = {1'b0, load3, 1'b1, main3, 1'b1, lhs3, 1'b1, rhs3,
          op_ready3, extd3, extc3, aluc3, done3, err3};
    check("dut4_outs", a4, expect_outs(phase, m_op, m_dst, m_src, m_rhs, 4));
    check("dut3_outs", a3, expect_outs(phase, m_op, m_dst, m_src, m_rhs, 3));
    check("inv_main_one_driver", 32'(($countones(~main4) + (extd4 ? 0 : 1)) <= 1), 1);
    check("inv_lhs_rhs_load", 32'(($countones(~lhs4) <= 1) && ($countones(~rhs4) <= 1) &&
                                  ($countones(load4) <= 1)), 1);
    hold_ok = ((load4 == 4'h0 && !extc4) || prev_mdrv) && (!aluc4 || (prev_ldrv && prev_rdrv));
    check("inv_strobe_after_driver", 32'(hold_ok), 1);
    prev_mdrv = (main4 != 4'hF) || !extd4;
    prev_ldrv = lhs4 != 4'hF;
    prev_rdrv = rhs4 != 4'hF;
  end

  // Data model of the register bank around dut4.
  logic [7:0] gpr [4] = '{default: 8'h00};
  logic [7:0] sink = 8'h00, alu_l = 8'h00, alu_r = 8'h00;
  logic [3:0] prev_load = 4'h0;
  logic       prev_extc = 1'b0, prev_aluc = 1'b0;

  function automatic logic [7:0] bus_val(input logic [3:0] sel_n);
    for (int i = 0; i < 4; i++) if (!sel_n[i]) return gpr[i];
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    logic [7:0] main_v;
    main_v = !extd4 ? ext_data : bus_val(main4);
    if (aluc4 && !prev_aluc) begin alu_l = bus_val(lhs4); alu_r = bus_val(rhs4); end
    if (extc4 && !prev_extc) sink = main_v;
    for (int i = 0; i < 4; i++) if (load4[i] && !prev_load[i]) gpr[i] = main_v;
    prev_load = load4; prev_extc = extc4; prev_aluc = aluc4;
  end

  task automatic start_op(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s,
                          input logic [1:0] r);
    @(negedge clk);
    op_code = op; dst_idx = d; src_idx = s; rhs_idx = r; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  int acc[$];
  int done_cnt;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (5) begin
      next_cycle();
      check("idle_outs", {op_ready4, load4, main4, lhs4, rhs4, extd4},
            {1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1});
    end

    // LOAD_EXT dst=2 with 8'hAA on the Main bus.
    ext_data = 8'hAA;
    start_op(LD, 2'd2, 2'd0, 2'd0);
    next_cycle(); check("ld_c1", {extd4, load4}, {1'b1 ^ 1'b1, 4'b0000});
    next_cycle(); check("ld_c2", {extd4, load4}, {1'b0, 4'b0100});
    next_cycle(); check("ld_c3", {extd4, load4, done4}, {1'b0, 4'b0000, 1'b1});
    next_cycle(); check("ld_c4", {extd4, done4, op_ready4}, {1'b1, 1'b0, 1'b1});
    check("gpr_c_value", gpr[2], 8'hAA);

    // MOV src=2 dst=0.
    start_op(MV, 2'd0, 2'd2, 2'd0);
    next_cycle(); check("mov_c1", {main4, load4}, {4'b1011, 4'b0000});
    next_cycle(); check("mov_c2", {main4, load4}, {4'b1011, 4'b0001});
    next_cycle(); check("mov_c3", {main4, load4, done4}, {4'b1011, 4'b0000, 1'b1});
    check("gpr_a_value", gpr[0], 8'hAA);

    // ALU_READ src=0 rhs=2, then src==rhs=1.
    start_op(AL, 2'd0, 2'd0, 2'd2);
    next_cycle(); check("alu_c1", {lhs4, rhs4, aluc4}, {4'b1110, 4'b1011, 1'b0});
    next_cycle(); check("alu_c2", {lhs4, rhs4, aluc4}, {4'b1110, 4'b1011, 1'b1});
    next_cycle(); check("alu_c3", {lhs4, rhs4, aluc4, done4}, {4'b1110, 4'b1011, 1'b0, 1'b1});
    check("alu_operands", {alu_l, alu_r}, {8'hAA, 8'hAA});
    start_op(AL, 2'd0, 2'd1, 2'd1);
    next_cycle(); check("alu_same_c1", {lhs4, rhs4}, {4'b1101, 4'b1101});
    repeat (2) next_cycle();

    // Back-to-back: op_valid held high across MOV 3,3 / STORE src0 / LOAD dst1.
    done_cnt = 0;
    @(negedge clk);
    op_code = MV; dst_idx = 2'd3; src_idx = 2'd3; op_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      logic rdy, v;
      if (c > 0) @(negedge clk);
      rdy = op_ready4; v = op_valid;
      if (done4) done_cnt++;
      if (c == 3) check("mov33_release", {done4, main4, load4, extd4}, {1'b1, 4'hF, 4'h0, 1'b1});
      @(posedge clk);
      #1;
      if (rdy && v) begin
        acc.push_back(c);
        if (acc.size() == 1) begin op_code = ST; src_idx = 2'd0; dst_idx = 2'd2; end
        else if (acc.size() == 2) begin op_code = LD; dst_idx = 2'd1; ext_data = 8'h55; end
        else op_valid = 1'b0;
      end
    end
    check("b2b_accept_count", acc.size(), 3);
    if (acc.size() == 3) check("b2b_spacing", {acc[1] - acc[0], acc[2] - acc[1]}, {32'd4, 32'd4});
    check("b2b_done_count", done_cnt, 3);
    check("store_sink", sink, 8'hAA);
    check("gpr_b_value", gpr[1], 8'h55);

    // Out-of-range dst for the 3-register instance.
    ext_data = 8'h3C;
    start_op(LD, 2'd3, 2'd0, 2'd0);
    next_cycle(); check("err_c1", {extd3, extd4}, {1'b1, 1'b0});
    next_cycle(); check("err_c2", {load3, extd3, load4}, {3'b000, 1'b1, 4'b1000});
    next_cycle(); check("err_c3", {done3, err3, done4, err4}, {1'b1, 1'b1, 1'b1, 1'b0});
    next_cycle();

    // Reset during STROBE of a MOV: everything drops at once, no done.
    start_op(MV, 2'd1, 2'd2, 2'd0);
    next_cycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_op", {op_ready4, load4, main4, lhs4, rhs4, extd4, extc4, aluc4, done4, err4},
             {1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (4) begin next_cycle(); if (done4 || done3) done_cnt++; end
    check("rst_no_done", done_cnt, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
